// File: rtl/hdlc_pkg.sv
// hdlc_pkg: constants, error codes and state encoding shared by the HDLC
// receive deframer and the FCS-16 byte update. The transmit framer will
// reuse it as well.
package hdlc_pkg;

  // Framing bytes
  localparam logic [7:0] HDLC_FLAG = 8'h7E;
  localparam logic [7:0] HDLC_ESC  = 8'h7D;
  localparam logic [7:0] HDLC_XOR  = 8'h20;

  // CRC-16/X.25: reflected polynomial, all-ones preset. A frame whose
  // received FCS is correct leaves this fixed residual in the register.
  localparam logic [15:0] FCS16_INIT = 16'hFFFF;
  localparam logic [15:0] FCS16_GOOD = 16'hF0B8;
  localparam logic [15:0] FCS16_POLY = 16'h8408;

  // Frame termination codes reported with frame_done
  localparam logic [2:0] ERR_OK       = 3'd0;
  localparam logic [2:0] ERR_FCS      = 3'd1;
  localparam logic [2:0] ERR_ABORT    = 3'd2;
  localparam logic [2:0] ERR_OVERFLOW = 3'd3;
  localparam logic [2:0] ERR_RUNT     = 3'd4;

  // Deframer states
  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_IDLE = 2'd1,
    ST_DATA = 2'd2,
    ST_ESC  = 2'd3
  } state_t;

endpackage

// File: rtl/fcs16_update.sv
// fcs16_update: combinational CRC-16/X.25 update for one byte.
// The byte is shifted in LSB first against the reflected polynomial.
// Ports:
//   crc_in   [15:0] current CRC register
//   data_in  [7:0]  byte to absorb
//   crc_out  [15:0] CRC register after absorbing data_in
module fcs16_update
  import hdlc_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data_in[i]) begin
        crc_out = (crc_out >> 1) ^ FCS16_POLY;
      end else begin
        crc_out = crc_out >> 1;
      end
    end
  end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// hdlc_rx_deframer: byte-stream HDLC-like deframer. Finds 0x7E flags,
// removes 0x7D escapes, checks FCS-16 and delivers payload bytes with the
// two trailing FCS bytes stripped. The input cannot be stalled.
// Ports:
//   mclk, reset          clock, asynchronous active-high reset
//   in_data, in_strobe   received byte and its one-cycle strobe
//   out_data, out_valid  unescaped payload byte and its pulse
//   out_first            marks the first payload byte of a frame
//   frame_done           one-cycle pulse at frame termination
//   err_code, frame_len  termination code and delivered byte count
module hdlc_rx_deframer
  import hdlc_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = 9
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_strobe,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_first,
  output logic             frame_done,
  output logic [2:0]       err_code,
  output logic [LEN_W-1:0] frame_len
);

  localparam logic [LEN_W-1:0] LEN_TWO   = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_THREE = LEN_W'(3);
  localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_LEN + 2);

  state_t           state_q, state_d;
  logic [7:0]       hold0_q, hold0_d;
  logic [7:0]       hold1_q, hold1_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [15:0]      fcs_q, fcs_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_first_q, out_first_d;
  logic             frame_done_q, frame_done_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;

  logic             do_push;
  logic             clear_frame;
  logic [7:0]       push_byte;
  logic [15:0]      fcs_upd;
  logic [LEN_W-1:0] delivered;

  fcs16_update u_fcs16 (
    .crc_in  (fcs_q),
    .data_in (push_byte),
    .crc_out (fcs_upd)
  );

  // Bytes already handed out: everything except the two still in the lag line
  assign delivered = (count_q >= LEN_TWO) ? (count_q - LEN_TWO) : '0;

  always_comb begin
    state_d      = state_q;
    hold0_d      = hold0_q;
    hold1_d      = hold1_q;
    count_d      = count_q;
    fcs_d        = fcs_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    out_first_d  = 1'b0;
    frame_done_d = 1'b0;
    err_code_d   = err_code_q;
    frame_len_d  = frame_len_q;
    do_push      = 1'b0;
    clear_frame  = 1'b0;
    push_byte    = in_data;

    if (in_strobe) begin
      case (state_q)
        ST_HUNT: begin
          if (in_data == HDLC_FLAG) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (in_data == HDLC_ESC) begin
            state_d = ST_ESC;
          end else if (in_data != HDLC_FLAG) begin
            do_push = 1'b1;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (in_data == HDLC_FLAG) begin
            frame_done_d = 1'b1;
            frame_len_d  = delivered;
            if (count_q < LEN_THREE)        err_code_d = ERR_RUNT;
            else if (fcs_q == FCS16_GOOD)   err_code_d = ERR_OK;
            else                            err_code_d = ERR_FCS;
            clear_frame  = 1'b1;
            state_d      = ST_IDLE;
          end else if (in_data == HDLC_ESC) begin
            state_d = ST_ESC;
          end else begin
            do_push = 1'b1;
          end
        end
        ST_ESC: begin
          // The aborting flag also opens the next frame
          if (in_data == HDLC_FLAG) begin
            frame_done_d = 1'b1;
            frame_len_d  = delivered;
            err_code_d   = ERR_ABORT;
            clear_frame  = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            push_byte = in_data ^ HDLC_XOR;
            do_push   = 1'b1;
            state_d   = ST_DATA;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (do_push) begin
      if (count_q == LEN_LIMIT) begin
        // This push would exceed payload plus FCS: give up and resync
        frame_done_d = 1'b1;
        frame_len_d  = delivered;
        err_code_d   = ERR_OVERFLOW;
        clear_frame  = 1'b1;
        state_d      = ST_HUNT;
      end else begin
        count_d = count_q + 1'b1;
        fcs_d   = fcs_upd;
        hold1_d = hold0_q;
        hold0_d = push_byte;
        // Only bytes two behind the newest can be payload, never FCS
        if (count_q >= LEN_TWO) begin
          out_valid_d = 1'b1;
          out_data_d  = hold1_q;
          out_first_d = (count_q == LEN_TWO);
        end
      end
    end

    if (clear_frame) begin
      count_d = '0;
      fcs_d   = FCS16_INIT;
      hold0_d = '0;
      hold1_d = '0;
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_HUNT;
      hold0_q      <= '0;
      hold1_q      <= '0;
      count_q      <= '0;
      fcs_q        <= FCS16_INIT;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_first_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_code_q   <= '0;
      frame_len_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold0_q      <= hold0_d;
      hold1_q      <= hold1_d;
      count_q      <= count_d;
      fcs_q        <= fcs_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_first_q  <= out_first_d;
      frame_done_q <= frame_done_d;
      err_code_q   <= err_code_d;
      frame_len_q  <= frame_len_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_first  = out_first_q;
  assign frame_done = frame_done_q;
  assign err_code   = err_code_q;
  assign frame_len  = frame_len_q;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// tb_hdlc_rx_deframer: directed streams into two deframers (default size and
// MAX_LEN=4); expectations are queued at stimulus time and popped by a
// monitor on every out_valid/frame_done.
module tb_hdlc_rx_deframer;

  logic       mclk;
  logic       reset;
  logic [7:0] in_data;
  logic       strobe_a, strobe_b;

  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, a_first, b_first, a_done, b_done;
  logic [2:0] a_err, b_err;
  logic [8:0] a_len, b_len;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       done;
    logic [7:0] data;
    logic       first;
    logic [2:0] err;
    logic [8:0] len;
  } evt_t;

  evt_t q0[$];
  evt_t q1[$];
  logic [7:0] pay[$];

  hdlc_rx_deframer #(.MAX_LEN(256), .LEN_W(9)) dut_a (
    .mclk(mclk), .reset(reset), .in_data(in_data), .in_strobe(strobe_a),
    .out_data(a_data), .out_valid(a_valid), .out_first(a_first),
    .frame_done(a_done), .err_code(a_err), .frame_len(a_len)
  );

  hdlc_rx_deframer #(.MAX_LEN(4), .LEN_W(9)) dut_b (
    .mclk(mclk), .reset(reset), .in_data(in_data), .in_strobe(strobe_b),
    .out_data(b_data), .out_valid(b_valid), .out_first(b_first),
    .frame_done(b_done), .err_code(b_err), .frame_len(b_len)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // Reference CRC-16/X.25 over the global payload; returns the FCS to send
  function automatic logic [15:0] model_fcs();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (pay[k]) begin
      for (int i = 0; i < 8; i++) begin
        if (c[0] != pay[k][i]) c = {1'b0, c[15:1]} ^ 16'h8408;
        else                   c = {1'b0, c[15:1]};
      end
    end
    return ~c;
  endfunction

  task automatic exp_byte(input int sel, input logic [7:0] d, input logic f);
    evt_t e;
    e = '{done: 1'b0, data: d, first: f, err: 3'd0, len: 9'd0};
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic exp_done(input int sel, input logic [2:0] er, input logic [8:0] l);
    evt_t e;
    e = '{done: 1'b1, data: 8'd0, first: 1'b0, err: er, len: l};
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic tx(input int sel, input logic [7:0] b);
    @(negedge mclk);
    in_data = b;
    if (sel == 0) strobe_a = 1'b1; else strobe_b = 1'b1;
    @(negedge mclk);
    strobe_a = 1'b0;
    strobe_b = 1'b0;
  endtask

  task automatic tx_stuffed(input int sel, input logic [7:0] b);
    if (b == 8'h7E || b == 8'h7D) begin
      tx(sel, 8'h7D);
      tx(sel, b ^ 8'h20);
    end else begin
      tx(sel, b);
    end
  endtask

  // Sends pay (stuffed) + model FCS + closing flag, expecting a clean frame
  task automatic model_frame(input int sel);
    logic [15:0] f;
    f = model_fcs();
    foreach (pay[k]) exp_byte(sel, pay[k], k == 0);
    exp_done(sel, 3'd0, 9'(pay.size()));
    foreach (pay[k]) tx_stuffed(sel, pay[k]);
    tx_stuffed(sel, f[7:0]);
    tx_stuffed(sel, f[15:8]);
    tx(sel, 8'h7E);
  endtask

  task automatic mon(input int sel, input logic v, input logic f, input logic [7:0] d,
                     input logic dn, input logic [2:0] er, input logic [8:0] l);
    evt_t e;
    if (v && dn) begin
      checks++; errors++;
      $display("FAIL dut%0d overlap: out_valid and frame_done both high", sel);
    end else if (v || dn) begin
      checks++;
      if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
        errors++;
        $display("FAIL dut%0d unexpected: valid=%0b data=%02h done=%0b err=%0d len=%0d, required nothing",
                 sel, v, d, dn, er, l);
      end else begin
        e = (sel == 0) ? q0.pop_front() : q1.pop_front();
        if (e.done != dn) begin
          errors++;
          $display("FAIL dut%0d kind: got done=%0b data=%02h, required done=%0b data=%02h",
                   sel, dn, d, e.done, e.data);
        end else if (dn && (er != e.err || l != e.len)) begin
          errors++;
          $display("FAIL dut%0d done: got err=%0d len=%0d, required err=%0d len=%0d",
                   sel, er, l, e.err, e.len);
        end else if (!dn && (d != e.data || f != e.first)) begin
          errors++;
          $display("FAIL dut%0d byte: got %02h first=%0b, required %02h first=%0b",
                   sel, d, f, e.data, e.first);
        end else if (dn) begin
          $display("dut%0d frame_done err=%0d len=%0d ok", sel, er, l);
        end else begin
          $display("dut%0d byte %02h first=%0b ok", sel, d, f);
        end
      end
    end
  endtask

  always @(negedge mclk) mon(0, a_valid, a_first, a_data, a_done, a_err, a_len);
  always @(negedge mclk) mon(1, b_valid, b_first, b_data, b_done, b_err, b_len);

  task automatic check_zero(input string name);
    checks++;
    if ({a_data, a_valid, a_first, a_done, a_err, a_len} != '0 ||
        {b_data, b_valid, b_first, b_done, b_err, b_len} != '0) begin
      errors++;
      $display("FAIL %s: a=%02h/%0b/%0b/%0b/%0d/%0d b=%02h/%0b/%0b/%0b/%0d/%0d, required all zero",
               name, a_data, a_valid, a_first, a_done, a_err, a_len,
               b_data, b_valid, b_first, b_done, b_err, b_len);
    end else begin
      $display("%s outputs zero ok", name);
    end
  endtask

  logic [7:0] spec_good[11];
  logic [7:0] spec_bad[11];

  initial begin
    spec_good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
    spec_bad  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h36, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
    reset    = 1'b1;
    in_data  = 8'h00;
    strobe_a = 1'b0;
    strobe_b = 1'b0;
    #3;
    check_zero("reset");
    @(negedge mclk);
    @(negedge mclk);
    reset = 1'b0;

    // Good frame from the hand-computed vector
    for (int i = 0; i < 9; i++) exp_byte(0, spec_good[i], i == 0);
    exp_done(0, 3'd0, 9'd9);
    tx(0, 8'h7E);
    for (int i = 0; i < 11; i++) tx(0, spec_good[i]);
    tx(0, 8'h7E);

    // Same frame with one payload byte corrupted
    for (int i = 0; i < 9; i++) exp_byte(0, spec_bad[i], i == 0);
    exp_done(0, 3'd1, 9'd9);
    for (int i = 0; i < 11; i++) tx(0, spec_bad[i]);
    tx(0, 8'h7E);

    // Escaped payload bytes 7E 7D 41
    tx(0, 8'h7E);
    pay = '{8'h7E, 8'h7D, 8'h41};
    model_frame(0);

    // Abort: 7E 41 42 43 7D 7E -> 41 delivered, then abort
    exp_byte(0, 8'h41, 1'b1);
    exp_done(0, 3'd2, 9'd1);
    tx(0, 8'h7E); tx(0, 8'h41); tx(0, 8'h42); tx(0, 8'h43); tx(0, 8'h7D); tx(0, 8'h7E);

    // Runt: 7E 41 7E
    exp_done(0, 3'd4, 9'd0);
    tx(0, 8'h7E); tx(0, 8'h41); tx(0, 8'h7E);

    // Empty frame: 7E 7E, no output
    tx(0, 8'h7E); tx(0, 8'h7E);

    // Recovery frame
    pay = '{8'hA5, 8'h00, 8'hFF, 8'h5A};
    model_frame(0);

    // Overflow on MAX_LEN=4
    for (int i = 0; i < 4; i++) exp_byte(1, 8'(i + 1), i == 0);
    exp_done(1, 3'd3, 9'd4);
    tx(1, 8'h7E);
    for (int i = 0; i < 7; i++) tx(1, 8'(i + 1));
    tx(1, 8'h7E);
    tx(1, 8'h7E);
    pay = '{8'h41, 8'h42, 8'h43};
    model_frame(1);

    // Reset in the middle of a frame
    exp_byte(0, 8'h31, 1'b1);
    tx(0, 8'h7E); tx(0, 8'h31); tx(0, 8'h32); tx(0, 8'h33);
    @(negedge mclk);
    #2 reset = 1'b1;
    #1 check_zero("midreset");
    @(negedge mclk);
    reset = 1'b0;
    tx(0, 8'h7E);
    pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    model_frame(0);

    repeat (10) @(negedge mclk);
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL dut0 drain: %0d events outstanding, required 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL dut1 drain: %0d events outstanding, required 0", q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
